memory_matrix_core: RTL and testbench
=====================================

// Module: memory_matrix_core
// PURPOSE
//  Parametrised next-generation game engine for the memory-matrix board: generates a random
//  board of TILES tiles, shows it for a timed window, then scores tile presses against it.
//  Sits between debounced board switches/keys and the tile LEDs and hex display.
//  Adds over the previous engine:
//   - TILES-wide board and internal edge detection, with no release-wait states.
//   - Per-press hit/miss scoring, a minimum lit-tile count, and win/lose event pulses.
// PARAMETERS
//  TILES         8           board width in tiles, 2..16
//  GUESS_W       4           width of guess counter; maximum guesses = 2**GUESS_W-1
//  MIN_TILES     2           minimum lit tiles a generated board must have, 1..TILES
//  SHOW_CYCLES   50000000    clk cycles the solution is shown in SHOW
//  FLASH_CYCLES  12500000    clk cycles per flash half-period
//  SEED          16'hACE1    LFSR reset value, must be non-zero
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  start         in   1        start/confirm key level, active-high
//  give_up       in   1        give-up key level, active-high
//  inc           in   1        add-guess key level, active-high
//  guess         in   TILES    tile switch levels, bit i = tile i
//  board_led     out  TILES    tile LEDs
//  flash_led     out  1        status LED
//  guesses_left  out  GUESS_W  remaining guesses, to the hex decoder
//  state_o       out  3        IDLE=0 GEN=1 LOAD=2 SHOW=3 PLAY=4 WIN=5 LOSE=6
//  win_pulse     out  1        one-cycle pulse on entry to WIN
//  lose_pulse    out  1        one-cycle pulse on entry to LOSE
// BEHAVIOUR
//  Reset values
//   - Outputs: state IDLE, board_led=0, flash_led=0, guesses_left=0, win_pulse=0, lose_pulse=0.
//   - Internals: lfsr=SEED, found=0, board=0, all edge-detect registers=0.
//  Reset has priority over every event, including reset in mid-SHOW or mid-PLAY.
//  Edges
//   - Registered rising-edge detect: start_r, inc_r, give_up_r.
//   - Tile presses: new = guess & ~guess_q. Falling edges are ignored.
//  LFSR
//   - 16-bit Galois LFSR, taps 16,14,13,11; steps every cycle in every state.
//   - Candidate board = lfsr[TILES-1:0].
//  State machine
//   - IDLE: found=0, guesses_left=0. start_r -> GEN.
//   - GEN: if popcount(candidate) >= MIN_TILES, latch board and go to LOAD next cycle;
//     otherwise stay in GEN and test the next candidate.
//   - LOAD: each inc_r adds 1 to guesses_left, saturating at 2**GUESS_W-1.
//     start_r with guesses_left>0 -> SHOW; start_r with guesses_left=0 is ignored.
//   - SHOW: board_led=board for exactly SHOW_CYCLES cycles, then PLAY.
//   - PLAY: board_led=found.
//      - hit = new & board & ~found; found |= hit.
//      - miss = |(new & ~board). Re-pressing an already-found tile is a no-op.
//      - On miss: guesses_left decrements by 1 per cycle, no matter how many wrong bits rise that cycle.
//      - (found|hit)==board -> WIN; this takes priority over a same-cycle miss (no decrement).
//      - Otherwise a miss that takes guesses_left to 0 -> LOSE.
//      - give_up_r -> LOSE. Priority: give_up over win over miss.
//   - WIN / LOSE: board_led=board, flash_led=flash phase. start_r -> IDLE.
//  Flash phase
//   - Toggles every FLASH_CYCLES cycles in IDLE, WIN and LOSE; cleared to 0 on entry to each.
//   - In IDLE: board_led={TILES{phase}}, flash_led=phase.
//   - flash_led=0 in all other states.
//  Counters
//   - The SHOW and flash counters are sized by $clog2 of their parameter.
//   - Both counters clear whenever their state is left.
// CONFIGURATION
//  MM_SCORE_EN defined
//   - Adds output port score [15:0], reset to 0 by reset only (not by IDLE).
//   - On WIN entry, score += guesses_left, saturating at 16'hFFFF.
//  MM_SCORE_EN undefined
//   - No score port and no score logic. All other behaviour is identical.
// TESTING  (TILES=8, SHOW_CYCLES=10, FLASH_CYCLES=4, MIN_TILES=2)
//  1. reset for 2 cycles, then idle
//     -> state_o=0, guesses_left=0, board_led/flash_led toggle 00/FF and 0/1 every 4 cycles.
//  2. start_r, then 3 inc_r
//     -> state LOAD, guesses_left=3; 20 inc_r -> saturates at 15; start_r with 0 guesses stays in LOAD.
//  3. In SHOW, sample board_led=B (popcount>=2), confirm PLAY after exactly 10 cycles; raise each bit of B singly
//     -> found accumulates; on the last bit win_pulse=1 for 1 cycle, state 5, guesses unchanged.
//  4. guesses=2, raise two wrong tiles on separate cycles -> guesses 1 then 0, lose_pulse, state 6, board_led=B.
//  5. Same cycle: final correct tile plus a wrong tile -> WIN, no decrement.
//     give_up_r during PLAY -> LOSE next cycle.
//  6. reset asserted in mid-SHOW -> next cycle state IDLE, all outputs at reset values.
//     With MM_SCORE_EN: score=3 after a win with 3 guesses left, and score survives the return to IDLE.

Source files
------------

// File: rtl/memory_matrix_core.sv
// Memory-matrix game engine: random TILES-wide board, timed show window, per-press scoring.
// Optional feature macro MM_SCORE_EN adds a saturating 16-bit score accumulated on each win.
module memory_matrix_core #(
  parameter int          TILES        = 8,
  parameter int          GUESS_W      = 4,
  parameter int          MIN_TILES    = 2,
  parameter int          SHOW_CYCLES  = 50000000,
  parameter int          FLASH_CYCLES = 12500000,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               give_up,
  input  logic               inc,
  input  logic [TILES-1:0]   guess,
  output logic [TILES-1:0]   board_led,
  output logic               flash_led,
  output logic [GUESS_W-1:0] guesses_left,
  output logic [2:0]         state_o,
  output logic               win_pulse,
  output logic               lose_pulse
`ifdef MM_SCORE_EN
  ,
  output logic [15:0]        score
`endif
);

  localparam int SHOW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
  localparam logic [GUESS_W-1:0] MAX_G      = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0, GEN = 3'd1, LOAD = 3'd2, SHOW = 3'd3,
    PLAY = 3'd4, WIN = 3'd5, LOSE = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [15:0]        lfsr, lfsr_n;
  logic [TILES-1:0]   board, board_n, found, found_n, guess_q;
  logic               start_q, inc_q, give_up_q;
  logic [SHOW_W-1:0]  show_cnt, show_n;
  logic [FLASH_W-1:0] flash_cnt, flash_n;
  logic               phase, phase_n;
  logic [GUESS_W-1:0] guesses_n;
  logic [TILES-1:0]   board_led_n;
  logic               flash_led_n, win_n, lose_n;
  logic               start_r, inc_r, give_up_r, miss;
  logic [TILES-1:0]   new_tiles, hit, cand;

  function automatic int popcount(input logic [TILES-1:0] v);
    int c = 0;
    for (int i = 0; i < TILES; i++) c += int'(v[i]);
    return c;
  endfunction

  assign start_r   = start & ~start_q;
  assign inc_r     = inc & ~inc_q;
  assign give_up_r = give_up & ~give_up_q;
  assign new_tiles = guess & ~guess_q;
  assign hit       = new_tiles & board & ~found;
  assign miss      = |(new_tiles & ~board);
  assign cand      = lfsr[TILES-1:0];
  assign lfsr_n    = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  assign state_o   = state;

  always_comb begin
    state_n     = state;
    board_n     = board;
    found_n     = found;
    guesses_n   = guesses_left;
    show_n      = show_cnt;
    flash_n     = flash_cnt;
    phase_n     = phase;
    win_n       = 1'b0;
    lose_n      = 1'b0;
    board_led_n = '0;
    flash_led_n = 1'b0;
    case (state)
      IDLE: begin
        found_n   = '0;
        guesses_n = '0;
        if (start_r) state_n = GEN;
      end
      GEN: begin
        if (popcount(cand) >= MIN_TILES) begin
          board_n = cand;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (inc_r && guesses_left != MAX_G) guesses_n = guesses_left + GUESS_W'(1);
        if (start_r && guesses_left != '0) state_n = SHOW;
      end
      SHOW: begin
        show_n = show_cnt + SHOW_W'(1);
        if (show_cnt == SHOW_LAST) state_n = PLAY;
      end
      PLAY: begin
        found_n = found | hit;
        // Give-up beats a completed board, which beats a same-cycle miss.
        if (give_up_r) begin
          state_n = LOSE;
          lose_n  = 1'b1;
        end else if ((found | hit) == board) begin
          state_n = WIN;
          win_n   = 1'b1;
        end else if (miss) begin
          guesses_n = guesses_left - GUESS_W'(1);
          if (guesses_left == GUESS_W'(1)) begin
            state_n = LOSE;
            lose_n  = 1'b1;
          end
        end
      end
      WIN, LOSE: begin
        if (start_r) begin
          state_n   = IDLE;
          found_n   = '0;
          guesses_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != SHOW) show_n = '0;
    // Flash phase runs only while staying in a flashing state; any entry restarts it at 0.
    if ((state_n == IDLE || state_n == WIN || state_n == LOSE) && state_n == state) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_n = '0;
        phase_n = ~phase;
      end else begin
        flash_n = flash_cnt + FLASH_W'(1);
      end
    end else begin
      flash_n = '0;
      phase_n = 1'b0;
    end

    case (state_n)
      IDLE: begin
        board_led_n = {TILES{phase_n}};
        flash_led_n = phase_n;
      end
      SHOW:      board_led_n = board_n;
      PLAY:      board_led_n = found_n;
      WIN, LOSE: begin
        board_led_n = board_n;
        flash_led_n = phase_n;
      end
      default:   board_led_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= SEED;
      board        <= '0;
      found        <= '0;
      guess_q      <= '0;
      start_q      <= 1'b0;
      inc_q        <= 1'b0;
      give_up_q    <= 1'b0;
      show_cnt     <= '0;
      flash_cnt    <= '0;
      phase        <= 1'b0;
      guesses_left <= '0;
      board_led    <= '0;
      flash_led    <= 1'b0;
      win_pulse    <= 1'b0;
      lose_pulse   <= 1'b0;
    end else begin
      state        <= state_n;
      lfsr         <= lfsr_n;
      board        <= board_n;
      found        <= found_n;
      guess_q      <= guess;
      start_q      <= start;
      inc_q        <= inc;
      give_up_q    <= give_up;
      show_cnt     <= show_n;
      flash_cnt    <= flash_n;
      phase        <= phase_n;
      guesses_left <= guesses_n;
      board_led    <= board_led_n;
      flash_led    <= flash_led_n;
      win_pulse    <= win_n;
      lose_pulse   <= lose_n;
    end
  end

`ifdef MM_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(guesses_left);

  // Score survives returns to IDLE; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) score <= '0;
    else if (win_n) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_memory_matrix_core.sv
// Directed bench for memory_matrix_core: reset/flash, guess loading table, win/lose/give-up games.
module tb_memory_matrix_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       give_up = 1'b0;
  logic       inc = 1'b0;
  logic [7:0] guess = '0;
  logic [7:0] board_led;
  logic       flash_led;
  logic [3:0] guesses_left;
  logic [2:0] state_o;
  logic       win_pulse;
  logic       lose_pulse;
`ifdef MM_SCORE_EN
  logic [15:0] score;
`endif

  int compared = 0;
  int mismatched = 0;

  memory_matrix_core #(
    .TILES(8), .GUESS_W(4), .MIN_TILES(2),
    .SHOW_CYCLES(10), .FLASH_CYCLES(4), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .give_up(give_up),
    .inc(inc),
    .guess(guess),
    .board_led(board_led),
    .flash_led(flash_led),
    .guesses_left(guesses_left),
    .state_o(state_o),
    .win_pulse(win_pulse),
    .lose_pulse(lose_pulse)
`ifdef MM_SCORE_EN
    ,
    .score(score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       i;
    logic [2:0] st;
    logic [3:0] g;
  } vec_t;

  vec_t load_vecs[9];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic i, input logic gu, input logic [7:0] t);
    start = s;
    inc = i;
    give_up = gu;
    guess = t;
    step(1);
  endtask

  function automatic int countOnes(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic enterLoad();
    int n = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("gen_entry", 32'(state_o), 32'd1);
    start = 1'b0;
    while (state_o != 3'd2 && n < 64) begin
      step(1);
      n++;
    end
    checkOutput("gen_to_load", 32'(state_o), 32'd2);
  endtask

  task automatic addGuesses(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic showAndPlay(output logic [7:0] b);
    int n = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("show_entry", 32'(state_o), 32'd3);
    b = board_led;
    checkOutput("board_min_tiles", 32'(countOnes(b) >= 2), 32'd1);
    start = 1'b0;
    while (state_o == 3'd3 && n < 40) begin
      step(1);
      n++;
    end
    checkOutput("show_cycles", 32'(n), 32'd10);
    checkOutput("play_entry", 32'(state_o), 32'd4);
    checkOutput("play_leds_clear", 32'(board_led), 32'd0);
  endtask

  task automatic returnToIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_return_state", 32'(state_o), 32'd0);
    checkOutput("idle_return_guesses", 32'(guesses_left), 32'd0);
    start = 1'b0;
    step(1);
  endtask

  task automatic findWrong(input logic [7:0] b, output logic [7:0] w1, output logic [7:0] w2, output bit have);
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) begin
        if (w1 == '0) w1 = 8'(1 << i);
        else if (w2 == '0) w2 = 8'(1 << i);
      end
    end
    have = (w2 != '0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b, lvl, w1, w2, last, rest, low;
    bit         have;
    int         exp_g;
    logic       ph;

    load_vecs[0] = '{1'b1, 1'b0, 3'd2, 4'd0};
    load_vecs[1] = '{1'b0, 1'b0, 3'd2, 4'd0};
    load_vecs[2] = '{1'b0, 1'b1, 3'd2, 4'd1};
    load_vecs[3] = '{1'b0, 1'b0, 3'd2, 4'd1};
    load_vecs[4] = '{1'b0, 1'b1, 3'd2, 4'd2};
    load_vecs[5] = '{1'b0, 1'b1, 3'd2, 4'd2};
    load_vecs[6] = '{1'b0, 1'b0, 3'd2, 4'd2};
    load_vecs[7] = '{1'b0, 1'b1, 3'd2, 4'd3};
    load_vecs[8] = '{1'b0, 1'b0, 3'd2, 4'd3};

    $display("[TB] reset and idle flash");
    step(2);
    reset = 1'b0;
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_guesses", 32'(guesses_left), 32'd0);
    checkOutput("reset_pulses", 32'({win_pulse, lose_pulse}), 32'd0);
`ifdef MM_SCORE_EN
    checkOutput("reset_score", 32'(score), 32'd0);
`endif
    for (int k = 0; k < 12; k++) begin
      ph = 1'((k / 4) % 2);
      checkOutput($sformatf("idle_board_led_%0d", k), 32'(board_led), 32'({8{ph}}));
      checkOutput($sformatf("idle_flash_led_%0d", k), 32'(flash_led), 32'(ph));
      step(1);
    end

    $display("[TB] guess loading table");
    enterLoad();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(load_vecs[k].s, load_vecs[k].i, 1'b0, 8'h00);
      checkOutput($sformatf("load_vec%0d_state", k), 32'(state_o), 32'(load_vecs[k].st));
      checkOutput($sformatf("load_vec%0d_guesses", k), 32'(guesses_left), 32'(load_vecs[k].g));
    end

    $display("[TB] game A: win with 3 guesses");
    showAndPlay(b);
    lvl = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        lvl |= 8'(1 << i);
        applyStimulus(1'b0, 1'b0, 1'b0, lvl);
        if (lvl == b) begin
          checkOutput("win_state", 32'(state_o), 32'd5);
          checkOutput("win_pulse_high", 32'(win_pulse), 32'd1);
          checkOutput("win_guesses", 32'(guesses_left), 32'd3);
          checkOutput("win_board_led", 32'(board_led), 32'(b));
          checkOutput("win_flash_led", 32'(flash_led), 32'd0);
        end else begin
          checkOutput("hit_state", 32'(state_o), 32'd4);
          checkOutput("hit_found_led", 32'(board_led), 32'(lvl));
          checkOutput("hit_guesses", 32'(guesses_left), 32'd3);
        end
      end
    end
    step(1);
    checkOutput("win_pulse_one_cycle", 32'(win_pulse), 32'd0);
    checkOutput("win_state_held", 32'(state_o), 32'd5);
`ifdef MM_SCORE_EN
    checkOutput("score_after_win", 32'(score), 32'd3);
`endif
    returnToIdle();
`ifdef MM_SCORE_EN
    checkOutput("score_survives_idle", 32'(score), 32'd3);
`endif

    $display("[TB] game B: saturation and give-up");
    enterLoad();
    addGuesses(20);
    checkOutput("guesses_saturate", 32'(guesses_left), 32'd15);
    showAndPlay(b);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("giveup_state", 32'(state_o), 32'd6);
    checkOutput("giveup_lose_pulse", 32'(lose_pulse), 32'd1);
    checkOutput("giveup_board_led", 32'(board_led), 32'(b));
    checkOutput("giveup_guesses", 32'(guesses_left), 32'd15);
    returnToIdle();

    $display("[TB] game C: lose on misses");
    enterLoad();
    addGuesses(2);
    showAndPlay(b);
    findWrong(b, w1, w2, have);
    if (have) begin
      lvl = w1;
      applyStimulus(1'b0, 1'b0, 1'b0, lvl);
      checkOutput("miss1_guesses", 32'(guesses_left), 32'd1);
      checkOutput("miss1_state", 32'(state_o), 32'd4);
      checkOutput("miss1_no_lose", 32'(lose_pulse), 32'd0);
      lvl |= w2;
      applyStimulus(1'b0, 1'b0, 1'b0, lvl);
      checkOutput("miss2_guesses", 32'(guesses_left), 32'd0);
      checkOutput("miss2_state", 32'(state_o), 32'd6);
      checkOutput("miss2_lose_pulse", 32'(lose_pulse), 32'd1);
      checkOutput("lose_board_led", 32'(board_led), 32'(b));
      step(1);
      checkOutput("lose_pulse_one_cycle", 32'(lose_pulse), 32'd0);
    end
    returnToIdle();

    $display("[TB] game D: multi-miss, re-press, win beats miss");
    enterLoad();
    addGuesses(3);
    showAndPlay(b);
    findWrong(b, w1, w2, have);
    exp_g = 3;
    if (have) begin
      lvl = w1 | w2;
      applyStimulus(1'b0, 1'b0, 1'b0, lvl);
      exp_g = 2;
      checkOutput("multi_miss_one_decrement", 32'(guesses_left), 32'(exp_g));
      checkOutput("multi_miss_state", 32'(state_o), 32'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    end
    last = '0;
    for (int i = 0; i < 8; i++) if (b[i]) last = 8'(1 << i);
    rest = b & ~last;
    low = '0;
    for (int i = 7; i >= 0; i--) if (rest[i]) low = 8'(1 << i);
    lvl = '0;
    for (int i = 0; i < 8; i++) begin
      if (rest[i]) begin
        lvl |= 8'(1 << i);
        applyStimulus(1'b0, 1'b0, 1'b0, lvl);
        checkOutput("partial_found_led", 32'(board_led), 32'(lvl));
      end
    end
    lvl &= ~low;
    applyStimulus(1'b0, 1'b0, 1'b0, lvl);
    lvl |= low;
    applyStimulus(1'b0, 1'b0, 1'b0, lvl);
    checkOutput("repress_no_decrement", 32'(guesses_left), 32'(exp_g));
    checkOutput("repress_found_led", 32'(board_led), 32'(rest));
    checkOutput("repress_state", 32'(state_o), 32'd4);
    lvl |= last | (have ? w1 : 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, lvl);
    checkOutput("win_over_miss_state", 32'(state_o), 32'd5);
    checkOutput("win_over_miss_pulse", 32'(win_pulse), 32'd1);
    checkOutput("win_over_miss_guesses", 32'(guesses_left), 32'(exp_g));
`ifdef MM_SCORE_EN
    checkOutput("score_accumulates", 32'(score), 32'(3 + exp_g));
`endif
    returnToIdle();

    $display("[TB] game E: reset during SHOW");
    enterLoad();
    addGuesses(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("show_before_reset", 32'(state_o), 32'd3);
    start = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    checkOutput("midshow_reset_state", 32'(state_o), 32'd0);
    checkOutput("midshow_reset_leds", 32'({board_led, flash_led}), 32'd0);
    checkOutput("midshow_reset_guesses", 32'(guesses_left), 32'd0);
    checkOutput("midshow_reset_pulses", 32'({win_pulse, lose_pulse}), 32'd0);
`ifdef MM_SCORE_EN
    checkOutput("midshow_reset_score", 32'(score), 32'd0);
`endif
    reset = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
